// File: rtl/asm_pkg.sv
// Shared definitions for the serial byte assembler.
//   state_t      : assembler state enumeration (IDLE, SHIFT, PARITY, LOAD)
//   PAR_EVEN/ODD : parity-mode constants for the PARITY_ODD parameter
//   expected_parity : parity bit a sender must append to a given payload XOR
package asm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        LOAD   = 2'd3
    } state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // payload_xor is the XOR of all payload bits; odd parity inverts it.
    function automatic logic expected_parity(input logic payload_xor, input logic odd_mode);
        return payload_xor ^ odd_mode;
    endfunction

endpackage

// File: rtl/shift_in_reg.sv
// LSB-first serial shift register with a saturating bit counter.
//   clk, rst       : clock, asynchronous active-high reset
//   i_clear        : clear shift register and counter (frame start)
//   i_shift        : accept i_bit this cycle
//   i_bit          : serial data bit
//   o_shreg        : current shift register contents
//   o_shreg_next   : contents after shifting i_bit in (for same-edge capture)
//   o_last         : the next accepted bit completes the payload
module shift_in_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_shreg,
    output logic [WIDTH-1:0] o_shreg_next,
    output logic             o_last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_shreg_next;

    // New bit enters at the MSB so the first bit received ends up at bit 0.
    assign w_shreg_next = (r_shreg >> 1) | ({{(WIDTH-1){1'b0}}, i_bit} << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (i_shift && (r_count != CW'(WIDTH))) begin
            // Counter saturates at WIDTH rather than wrapping.
            r_shreg <= w_shreg_next;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_shreg      = r_shreg;
    assign o_shreg_next = w_shreg_next;
    assign o_last       = (r_count == CW'(WIDTH - 1));

endmodule

// File: rtl/byte_assembler.sv
// Serial-to-parallel word assembler with optional parity check.
//   clk       : clock, all state changes on rising edge
//   rst       : asynchronous active-high reset
//   start     : begin (or restart) a frame
//   bit_in    : serial data bit, LSB first
//   bit_valid : qualifies bit_in
//   abort     : cancel the current frame (highest priority)
//   data      : assembled word, held between loads
//   ena       : one-cycle load strobe for the downstream register
//   busy      : state is not IDLE
//   par_err   : sticky parity failure, cleared when a start is accepted
module byte_assembler
    import asm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] data,
    output logic             ena,
    output logic             busy,
    output logic             par_err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_ena;
    logic             r_par_err;

    logic [WIDTH-1:0] w_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic             w_last;
    logic             w_clear;
    logic             w_shift;
    logic             w_par_exp;

    // Start is accepted from IDLE unconditionally and from SHIFT/PARITY
    // unless abort wins; LOAD ignores start.
    assign w_clear = (r_state == IDLE && start) ||
                     ((r_state == SHIFT || r_state == PARITY) && start && !abort);
    assign w_shift = (r_state == SHIFT) && bit_valid && !abort && !start;
    assign w_par_exp = expected_parity(^w_shreg, PARITY_ODD != PAR_EVEN);

    shift_in_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_shift      (w_shift),
        .i_bit        (bit_in),
        .o_shreg      (w_shreg),
        .o_shreg_next (w_shreg_next),
        .o_last       (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_ena     <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= SHIFT;
                        r_par_err <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (start) begin
                        r_state   <= SHIFT;
                        r_par_err <= 1'b0;
                    end else if (bit_valid && w_last) begin
                        if (PARITY_EN != 0) begin
                            r_state <= PARITY;
                        end else begin
                            // Capture including the bit arriving on this edge.
                            r_state <= LOAD;
                            r_ena   <= 1'b1;
                            r_data  <= w_shreg_next;
                        end
                    end
                end
                PARITY: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (start) begin
                        r_state   <= SHIFT;
                        r_par_err <= 1'b0;
                    end else if (bit_valid) begin
                        if (bit_in != w_par_exp) begin
                            r_state   <= IDLE;
                            r_par_err <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                            r_ena   <= 1'b1;
                            r_data  <= w_shreg;
                        end
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Abort arriving during LOAD must still suppress the strobe, which is
    // only possible by gating the registered strobe with the live input.
    assign ena     = r_ena && !abort;
    assign data    = r_data;
    assign busy    = (r_state != IDLE);
    assign par_err = r_par_err;

endmodule

// File: tb/tb_byte_assembler.sv
module tb_byte_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data;
    logic       ena;
    logic       busy;
    logic       par_err;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_perr = 1'b0;

    always #5 clk = ~clk;

    byte_assembler #(
        .WIDTH      (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .abort     (abort),
        .data      (data),
        .ena       (ena),
        .busy      (busy),
        .par_err   (par_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Even parity bit: makes the total count of ones even.
    function automatic logic even_par(input logic [7:0] w);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += (w / (2 ** i)) % 2;
        return logic'(ones % 2);
    endfunction

    task automatic tick(input logic s, input logic v, input logic b, input logic a);
        start = s; bit_valid = v; bit_in = b; abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input int gaps);
        for (int i = 0; i < n; i++) begin
            int g = $urandom_range(0, gaps);
            for (int k = 0; k < g; k++) begin
                tick(1'b0, 1'b0, 1'($urandom), 1'b0);
                chk("gap_ena", 32'(ena), 32'd0);
            end
            tick(1'b0, 1'b1, w[i], 1'b0);
            chk("bit_ena", 32'(ena), 32'd0);
            chk("bit_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic start_frame();
        tick(1'b1, 1'($urandom), 1'($urandom), 1'b0);
        exp_perr = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_perr", 32'(par_err), 32'd0);
        chk("start_ena", 32'(ena), 32'd0);
    endtask

    task automatic finish_parity(input logic [7:0] w, input logic ok);
        logic pbit;
        pbit = ok ? even_par(w) : ~even_par(w);
        tick(1'b0, 1'b1, pbit, 1'b0);
        if (ok) begin
            exp_data = w;
            chk("load_ena", 32'(ena), 32'd1);
            chk("load_data", 32'(data), 32'(w));
            chk("load_busy", 32'(busy), 32'd1);
        end else begin
            exp_perr = 1'b1;
            chk("perr_ena", 32'(ena), 32'd0);
            chk("perr_data", 32'(data), 32'(exp_data));
            chk("perr_flag", 32'(par_err), 32'd1);
            chk("perr_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic post_check();
        idle_tick();
        chk("post_ena", 32'(ena), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_data", 32'(data), 32'(exp_data));
        chk("post_perr", 32'(par_err), 32'(exp_perr));
    endtask

    task automatic run_frame(input logic [7:0] w, input logic ok, input int gaps);
        start_frame();
        send_bits(w, 8, gaps);
        finish_parity(w, ok);
        post_check();
        $display("frame word=%02h parity_ok=%0d data=%02h par_err=%0d", w, ok, data, par_err);
    endtask

    task automatic abort_frame(input logic [7:0] w, input int nbits, input int gaps);
        start_frame();
        send_bits(w, nbits, gaps);
        tick(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ena", 32'(ena), 32'd0);
        chk("abort_data", 32'(data), 32'(exp_data));
        post_check();
        $display("abort after %0d bits word=%02h data=%02h", nbits, w, data);
    endtask

    initial begin
        #2;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(par_err), 32'd0);
        #1 rst = 1'b0;
        idle_tick();
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_ignores_bits", 32'(busy), 32'd0);

        // Clean frame 0x53 (bits 1,1,0,0,1,0,1,0), then the same with bad parity.
        run_frame(8'h53, 1'b1, 0);
        run_frame(8'h53, 1'b0, 0);
        idle_tick();
        chk("perr_sticky", 32'(par_err), 32'd1);

        // Gapped bits.
        run_frame(8'hA5, 1'b1, 3);

        // Abort after 4 bits, then a full frame.
        abort_frame(8'hFF, 4, 1);
        run_frame(8'h3C, 1'b1, 0);

        // Restart after 5 bits.
        start_frame();
        send_bits(8'h1F, 5, 1);
        run_frame(8'hF0, 1'b1, 0);

        // Abort while waiting for the parity bit.
        start_frame();
        send_bits(8'h99, 8, 0);
        tick(1'b0, 1'b1, even_par(8'h99), 1'b1);
        chk("abort_par_busy", 32'(busy), 32'd0);
        chk("abort_par_ena", 32'(ena), 32'd0);
        chk("abort_par_data", 32'(data), 32'(exp_data));
        $display("abort in parity word=99 data=%02h", data);

        // Abort arriving in the load cycle suppresses the strobe.
        start_frame();
        send_bits(8'h6E, 8, 0);
        tick(1'b0, 1'b1, even_par(8'h6E), 1'b0);
        abort = 1'b1;
        #1;
        chk("abort_load_ena", 32'(ena), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_load_busy", 32'(busy), 32'd0);
        chk("abort_load_ena2", 32'(ena), 32'd0);
        $display("abort in load word=6E");
        run_frame(8'h81, 1'b1, 0);

        // Mid-frame asynchronous reset between edges.
        start_frame();
        send_bits(8'h77, 3, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_data", 32'(data), 32'd0);
        chk("arst_ena", 32'(ena), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_perr", 32'(par_err), 32'd0);
        #1 rst = 1'b0;
        exp_data = 8'h00;
        exp_perr = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk("arst_waits", 32'(busy), 32'd0);
        $display("async reset mid-frame data=%02h", data);
        run_frame(8'hC3, 1'b1, 2);

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] w;
            int kind;
            w = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                run_frame(w, 1'b1, 3);
            end else if (kind < 8) begin
                run_frame(w, 1'b0, 3);
            end else if (kind == 8) begin
                abort_frame(w, $urandom_range(0, 7), 2);
            end else begin
                start_frame();
                send_bits(8'($urandom), $urandom_range(0, 7), 1);
                run_frame(w, 1'b1, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1);
    end

endmodule
